// File: rtl/axil_slave_bk_bridge_pkg.sv
// axil_slave_pkg: shared defaults and FSM state types for the AXI-Lite to
// back-end register bus bridge.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default bus widths
//   wr_state_t                      : write FSM states
//   rd_state_t                      : read FSM states
package axil_slave_pkg;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_REQ = 1'b1} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} rd_state_t;
endpackage

// File: rtl/axil_slave_bk_bridge_if.sv
// axil_slave_bk_bridge_if: AXI4-Lite AW/W/AR/R channel bundle (no B channel).
//   slave  modport : used by the bridge (drives readies, rvalid, rdata)
//   master modport : used by the fabric side (drives valids, addr, data)
interface axil_slave_bk_bridge_if
  import axil_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic [DATA_WIDTH-1:0]   axi_rdata;

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
           axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
           axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/axil_slave_rd_ctrl.sv
// axil_slave_rd_ctrl: read path of the bridge. Accepts an AR handshake,
// raises bk_rstart until bk_rdone, registers the returned data and presents
// it on R until the master takes it.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_en                   : gates new AR handshakes only
//   i_arvalid/o_arready, i_araddr : AR channel
//   o_rvalid/i_rready, o_rdata    : R channel
//   o_rstart, o_raddr, i_rdata, i_rdone : back-end read request/complete
module axil_slave_rd_ctrl
  import axil_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rstart,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_rdone
);
  rd_state_t             r_st;
  logic                  r_rstart;
  logic                  r_rvalid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_ar_hs;

  assign w_ar_hs   = (r_st == R_IDLE) && i_en && i_arvalid;
  assign o_arready = w_ar_hs;
  assign o_rstart  = r_rstart;
  assign o_rvalid  = r_rvalid;
  assign o_raddr   = r_raddr;
  assign o_rdata   = r_rdata;

  // i_rdone is only looked at in R_REQ, so stray completions are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st     <= R_IDLE;
      r_rstart <= 1'b0;
      r_rvalid <= 1'b0;
      r_raddr  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_st)
        R_IDLE: if (w_ar_hs) begin
          r_raddr  <= i_araddr;
          r_rstart <= 1'b1;
          r_st     <= R_REQ;
        end
        R_REQ: if (i_rdone) begin
          r_rdata  <= i_rdata;
          r_rstart <= 1'b0;
          r_rvalid <= 1'b1;
          r_st     <= R_RESP;
        end
        R_RESP: if (i_rready) begin
          r_rvalid <= 1'b0;
          r_st     <= R_IDLE;
        end
        default: begin
          r_rstart <= 1'b0;
          r_rvalid <= 1'b0;
          r_st     <= R_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/axil_slave_bk_bridge.sv
// axil_slave_bk_bridge: AXI4-Lite slave that turns AW+W and AR transactions
// into back-end bk_wstart / bk_rstart requests. No B channel is produced.
//   axi_aclk, axi_aresetn : clock, async active-low reset
//   s_axi                 : AXI-Lite AW/W/AR/R channels (slave modport)
//   bk_wstart, bk_waddr, bk_wdata, bk_wstrb : back-end write request
//   bk_rstart, bk_raddr, bk_rdata, bk_rdone : back-end read request/complete
//   bk_wdone              : back-end write complete (AXIL_BK_WDONE_EN only)
//   cc_aa_enable          : gates acceptance of new transactions
// Build option AXIL_BK_WDONE_EN: hold bk_wstart until bk_wdone instead of
// issuing a single-cycle pulse.
module axil_slave_bk_bridge
  import axil_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  axil_slave_bk_bridge_if.slave   s_axi,
  output logic                    bk_wstart,
  output logic [ADDR_WIDTH-1:0]   bk_waddr,
  output logic [DATA_WIDTH-1:0]   bk_wdata,
  output logic [DATA_WIDTH/8-1:0] bk_wstrb,
  output logic                    bk_rstart,
  output logic [ADDR_WIDTH-1:0]   bk_raddr,
  input  logic [DATA_WIDTH-1:0]   bk_rdata,
  input  logic                    bk_rdone,
`ifdef AXIL_BK_WDONE_EN
  input  logic                    bk_wdone,
`endif
  input  logic                    cc_aa_enable
);
  wr_state_t               r_wst;
  logic                    r_wstart;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    w_wr_hs;
  logic                    w_wr_done;

  // AW and W are only ever acknowledged together.
  assign w_wr_hs           = (r_wst == W_IDLE) && cc_aa_enable &&
                             s_axi.axi_awvalid && s_axi.axi_wvalid;
  assign s_axi.axi_awready = w_wr_hs;
  assign s_axi.axi_wready  = w_wr_hs;

`ifdef AXIL_BK_WDONE_EN
  assign w_wr_done = bk_wdone;
`else
  assign w_wr_done = 1'b1;
`endif

  assign bk_wstart = r_wstart;
  assign bk_waddr  = r_waddr;
  assign bk_wdata  = r_wdata;
  assign bk_wstrb  = r_wstrb;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wst    <= W_IDLE;
      r_wstart <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_wst)
        W_IDLE: if (w_wr_hs) begin
          r_waddr  <= s_axi.axi_awaddr;
          r_wdata  <= s_axi.axi_wdata;
          r_wstrb  <= s_axi.axi_wstrb;
          r_wstart <= 1'b1;
          r_wst    <= W_REQ;
        end
        W_REQ: if (w_wr_done) begin
          r_wstart <= 1'b0;
          r_wst    <= W_IDLE;
        end
        default: begin
          r_wstart <= 1'b0;
          r_wst    <= W_IDLE;
        end
      endcase
    end
  end

  axil_slave_rd_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd (
    .i_clk     (axi_aclk),
    .i_rst_n   (axi_aresetn),
    .i_en      (cc_aa_enable),
    .i_arvalid (s_axi.axi_arvalid),
    .o_arready (s_axi.axi_arready),
    .i_araddr  (s_axi.axi_araddr),
    .o_rvalid  (s_axi.axi_rvalid),
    .i_rready  (s_axi.axi_rready),
    .o_rdata   (s_axi.axi_rdata),
    .o_rstart  (bk_rstart),
    .o_raddr   (bk_raddr),
    .i_rdata   (bk_rdata),
    .i_rdone   (bk_rdone)
  );
endmodule

// File: tb/tb_axil_slave_bk_bridge.sv
module tb_axil_slave_bk_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bk_wstart, bk_rstart, bk_rdone, en;
  logic [14:0] bk_waddr, bk_raddr;
  logic [31:0] bk_wdata, bk_rdata;
  logic [3:0]  bk_wstrb;
`ifdef AXIL_BK_WDONE_EN
  logic        bk_wdone = 1'b1;
`endif
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  axil_slave_bk_bridge_if ax ();

  axil_slave_bk_bridge dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .s_axi        (ax),
    .bk_wstart    (bk_wstart),
    .bk_waddr     (bk_waddr),
    .bk_wdata     (bk_wdata),
    .bk_wstrb     (bk_wstrb),
    .bk_rstart    (bk_rstart),
    .bk_raddr     (bk_raddr),
    .bk_rdata     (bk_rdata),
    .bk_rdone     (bk_rdone),
`ifdef AXIL_BK_WDONE_EN
    .bk_wdone     (bk_wdone),
`endif
    .cc_aa_enable (en)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    ax.axi_awvalid = 0; ax.axi_wvalid = 0; ax.axi_arvalid = 0; ax.axi_rready = 0;
    bk_rdone = 0;
  endtask

  initial begin
    idle_in();
    ax.axi_awaddr = '0; ax.axi_wdata = '0; ax.axi_wstrb = '0; ax.axi_araddr = '0;
    bk_rdata = '0; en = 1;

    // reset
    #40;
    chk("rst_wstart", {31'd0, bk_wstart}, 0);
    chk("rst_rstart", {31'd0, bk_rstart}, 0);
    chk("rst_rvalid", {31'd0, ax.axi_rvalid}, 0);
    chk("rst_rdata", ax.axi_rdata, 0);
    chk("rst_waddr", {17'd0, bk_waddr}, 0);
    chk("rst_wdata", bk_wdata, 0);
    chk("rst_wstrb", {28'd0, bk_wstrb}, 0);
    chk("rst_raddr", {17'd0, bk_raddr}, 0);
    #40 rst_n = 1;
    tick(); tick();
    chk("idle_awready", {31'd0, ax.axi_awready}, 0);
    chk("idle_arready", {31'd0, ax.axi_arready}, 0);

    // single write
    ax.axi_awaddr = 15'h0100; ax.axi_wdata = 32'hDEADBEEF; ax.axi_wstrb = 4'hF;
    ax.axi_awvalid = 1; ax.axi_wvalid = 1; #1;
    chk("wr_awready", {31'd0, ax.axi_awready}, 1);
    chk("wr_wready", {31'd0, ax.axi_wready}, 1);
    chk("wr_nostart", {31'd0, bk_wstart}, 0);
    tick(); ax.axi_awvalid = 0; ax.axi_wvalid = 0; ax.axi_wdata = 32'h0;
    chk("wr_start", {31'd0, bk_wstart}, 1);
    chk("wr_waddr", {17'd0, bk_waddr}, 32'h0100);
    chk("wr_wdata", bk_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", {28'd0, bk_wstrb}, 4'hF);
    tick();
    chk("wr_start_off", {31'd0, bk_wstart}, 0);
    chk("wr_wdata_hold", bk_wdata, 32'hDEADBEEF);

    // stray rdone while read FSM idle
    bk_rdone = 1; bk_rdata = 32'h55555555; tick(); bk_rdone = 0;
    chk("stray_rdone_rvalid", {31'd0, ax.axi_rvalid}, 0);
    chk("stray_rdone_rdata", ax.axi_rdata, 0);

    // read with 3-cycle back-end latency and stalled rready
    ax.axi_araddr = 15'h0200; ax.axi_arvalid = 1; #1;
    chk("rd_arready", {31'd0, ax.axi_arready}, 1);
    tick(); ax.axi_arvalid = 0;
    chk("rd_rstart", {31'd0, bk_rstart}, 1);
    chk("rd_raddr", {17'd0, bk_raddr}, 32'h0200);
    tick(); tick();
    chk("rd_rstart_held", {31'd0, bk_rstart}, 1);
    tick(); bk_rdone = 1; bk_rdata = 32'h12345678;
    chk("rd_rvalid_early", {31'd0, ax.axi_rvalid}, 0);
    tick(); bk_rdone = 0; bk_rdata = 32'h0;
    chk("rd_rvalid", {31'd0, ax.axi_rvalid}, 1);
    chk("rd_rdata", ax.axi_rdata, 32'h12345678);
    chk("rd_rstart_off", {31'd0, bk_rstart}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hold_rvalid", {31'd0, ax.axi_rvalid}, 1);
      chk("rd_hold_rdata", ax.axi_rdata, 32'h12345678);
    end
    ax.axi_rready = 1; tick(); ax.axi_rready = 0;
    chk("rd_done_rvalid", {31'd0, ax.axi_rvalid}, 0);

    // enable gating
    en = 0;
    ax.axi_awaddr = 15'h0300; ax.axi_wdata = 32'hA5A5A5A5; ax.axi_wstrb = 4'h3;
    ax.axi_araddr = 15'h0400;
    ax.axi_awvalid = 1; ax.axi_wvalid = 1; ax.axi_arvalid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en0_awready", {31'd0, ax.axi_awready}, 0);
      chk("en0_arready", {31'd0, ax.axi_arready}, 0);
      chk("en0_wstart", {31'd0, bk_wstart}, 0);
      chk("en0_rstart", {31'd0, bk_rstart}, 0);
    end
    en = 1; #1;
    chk("en1_awready", {31'd0, ax.axi_awready}, 1);
    chk("en1_arready", {31'd0, ax.axi_arready}, 1);
    tick(); ax.axi_arvalid = 0;
    // aw/w kept high: W_REQ must not accept a second write
    chk("cc_wstart", {31'd0, bk_wstart}, 1);
    chk("cc_rstart", {31'd0, bk_rstart}, 1);
    chk("cc_waddr", {17'd0, bk_waddr}, 32'h0300);
    chk("cc_raddr", {17'd0, bk_raddr}, 32'h0400);
    chk("b2b_awready_busy", {31'd0, ax.axi_awready}, 0);
    ax.axi_wdata = 32'h0BADF00D; bk_rdone = 1; bk_rdata = 32'hCAFEF00D;
    tick(); bk_rdone = 0; ax.axi_rready = 1;
    chk("b2b_start_gap", {31'd0, bk_wstart}, 0);
    chk("b2b_awready", {31'd0, ax.axi_awready}, 1);
    chk("cc_rvalid", {31'd0, ax.axi_rvalid}, 1);
    chk("cc_rdata", ax.axi_rdata, 32'hCAFEF00D);
    tick(); ax.axi_awvalid = 0; ax.axi_wvalid = 0; ax.axi_rready = 0;
    chk("b2b_wdata", bk_wdata, 32'h0BADF00D);
    chk("cc_rvalid_off", {31'd0, ax.axi_rvalid}, 0);
    tick();

    // partial valid: lone awvalid is never acknowledged
    ax.axi_awaddr = 15'h0010; ax.axi_wdata = 32'h11223344; ax.axi_wstrb = 4'h5;
    ax.axi_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pv_awready", {31'd0, ax.axi_awready}, 0);
      chk("pv_wready", {31'd0, ax.axi_wready}, 0);
    end
    ax.axi_wvalid = 1; #1;
    chk("pv_hs_aw", {31'd0, ax.axi_awready}, 1);
    chk("pv_hs_w", {31'd0, ax.axi_wready}, 1);
    tick(); ax.axi_awvalid = 0; ax.axi_wvalid = 0;
    chk("pv_wstart", {31'd0, bk_wstart}, 1);
    chk("pv_wdata", bk_wdata, 32'h11223344);
    chk("pv_wstrb", {28'd0, bk_wstrb}, 4'h5);
    chk("pv_waddr", {17'd0, bk_waddr}, 32'h0010);
    tick();

    // reset mid-read aborts with no completion
    ax.axi_araddr = 15'h0777; ax.axi_arvalid = 1;
    tick(); ax.axi_arvalid = 0;
    chk("mr_rstart", {31'd0, bk_rstart}, 1);
    #2 rst_n = 0; #1;
    chk("mr_rstart_abort", {31'd0, bk_rstart}, 0);
    chk("mr_raddr_clr", {17'd0, bk_raddr}, 0);
    #10 rst_n = 1;
    tick(); bk_rdone = 1; bk_rdata = 32'h99999999;
    tick(); bk_rdone = 0;
    chk("mr_no_rvalid", {31'd0, ax.axi_rvalid}, 0);
    chk("mr_no_rstart", {31'd0, bk_rstart}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
